uart_tx_arbiter_wb: RTL and testbench
=====================================

Name: uart_tx_arbiter_wb

Overview:
Wishbone master that shares the simple UART transmitter between two byte-stream requesters.
- After reset, programs the UART clock divider register once.
- Then arbitrates between two valid/ready byte sources.
- For each granted byte: polls the UART status register until the transmitter is idle, then writes the byte to the data register.
- Sits between firmware-independent producers (debug trace, boot logger) and the UART's Wishbone slave port.

Parameters:
- CLK_DIV, 32'd1, value written to the divider register (offset 0x4) after reset.
- POLL_GAP, 4, idle cycles between a busy status read and the next poll; minimum 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-low
- req0_valid_i  in  1  requester 0 has a byte
- req0_data_i  in  8  requester 0 byte
- req0_ready_o  out  1  one-cycle pulse: req0 byte accepted
- req1_valid_i  in  1  requester 1 has a byte
- req1_data_i  in  8  requester 1 byte
- req1_ready_o  out  1  one-cycle pulse: req1 byte accepted
- m_wb_adr_o  out  1  word address bit [2]; 0 = status/data reg, 1 = divider reg
- m_wb_dat_o  out  32  write data
- m_wb_dat_i  in  32  read data; [15:8] status, [7:0] rx data
- m_wb_we_o  out  1  write enable
- m_wb_sel_o  out  4  byte lanes
- m_wb_stb_o  out  1  strobe
- m_wb_ack_i  in  1  slave acknowledge
- busy_o  out  1  byte latched and not yet written
- init_done_o  out  1  divider programmed

Behaviour:
- Reset (wb_rst_i==0 at posedge), all outputs:
  - m_wb_stb_o, m_wb_we_o, ready pulses, busy_o, init_done_o = 0
  - m_wb_adr_o = 0; m_wb_sel_o = 0; m_wb_dat_o = 0
  - state = INIT; rr pointer = 0
- Reset mid-transaction drops stb the next cycle; the latched byte is lost.
- States: INIT, INIT_WAIT, IDLE, POLL, POLL_WAIT, GAP, WRITE, WRITE_WAIT.
- INIT:
  - Drive adr=1, we=1, sel=4'hF, dat=CLK_DIV, stb=1.
  - Go to INIT_WAIT.
- INIT_WAIT:
  - Hold all signals until ack_i.
  - On ack cycle: register stb=0, set init_done_o=1, go to IDLE.
- IDLE:
  - If any valid_i, pick a winner. Latch its byte, pulse its ready_o for exactly one cycle, set busy_o=1, go to POLL.
  - Both requesters valid: the winner follows the arbitration rule (see Optional Feature).
- POLL:
  - Drive adr=0, we=0, sel=4'b0010, stb=1, go to POLL_WAIT.
  - sel[0] must stay 0 so the UART rx buffer is not consumed.
- POLL_WAIT:
  - Hold signals until ack_i.
  - On ack, sample m_wb_dat_i[9] (tx_busy) and drop stb.
  - tx_busy=1 -> GAP; tx_busy=0 -> WRITE.
- GAP:
  - Count POLL_GAP cycles with stb=0, then go to POLL.
- WRITE:
  - Drive adr=0, we=1, sel=4'b0001, dat={24'd0, byte}, stb=1, go to WRITE_WAIT.
- WRITE_WAIT:
  - Hold signals until ack_i.
  - On ack: drop stb, busy_o=0, go to IDLE.
- Wishbone rules:
  - stb is asserted for one request only and deasserted on the cycle after ack is seen.
  - adr/we/sel/dat are stable while stb=1.
  - ack_i while stb=0 is ignored.
  - No timeout: a missing ack stalls the FSM in the current *_WAIT state.
- A requester whose valid_i drops before it is granted is not served; no byte is lost or duplicated.
- Minimum bus cost per byte, with 1-cycle ack: 2 cycles poll + 2 cycles write.
- IDLE to IDLE with no busy polls: 5 cycles.

Optional Feature:
Macro UART_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous valid, grant the requester != last granted.
  - The rr pointer updates on each grant.
  - After reset, req0 wins first.
- Undefined: fixed priority, req0 always wins. The rr pointer is not implemented, so req1 can starve.

Test Plan:
- Reset release, CLK_DIV=32'd102 -> first bus cycle: adr=1, we=1, sel=F, dat=102. init_done_o=1 the cycle after ack. No ready pulse before init_done_o.
- req0 sends 0x41, slave status reads tx_busy=0 -> req0_ready_o pulses once. One read with sel=0010 precedes the write; the write has adr=0, sel=0001, dat=0x41. busy_o returns to 0.
- Slave returns tx_busy=1 for 3 polls, then 0 -> exactly 4 reads are issued, separated by ≥POLL_GAP cycles of stb=0, followed by one write.
- Both valid continuously, bytes 0xA0 (req0) and 0xB0 (req1), with UART_ARB_RR_EN -> writes alternate 0xA0, 0xB0, 0xA0, …
- Same stimulus as the previous case without the macro -> all writes are 0xA0; req1_ready_o is never asserted.
- Assert reset while in POLL_WAIT -> stb=0 next cycle. The sequence restarts with the INIT divider write. The dropped byte is never written.

Source files
------------

// File: rtl/uart_tx_arbiter_wb.sv
// Wishbone master sharing the UART transmitter between two byte requesters:
// programs the divider once, then polls tx_busy and writes each granted byte.
// Optional round-robin arbitration is enabled with `define UART_ARB_RR_EN.
module uart_tx_arbiter_wb #(
   parameter logic [31:0] CLK_DIV  = 32'd1,
   parameter int unsigned POLL_GAP = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req0_valid_i,
   input  logic [7:0]  req0_data_i,
   output logic        req0_ready_o,
   input  logic        req1_valid_i,
   input  logic [7:0]  req1_data_i,
   output logic        req1_ready_o,
   output logic        m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   input  logic [31:0] m_wb_dat_i,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_stb_o,
   input  logic        m_wb_ack_i,
   output logic        busy_o,
   output logic        init_done_o
);

   localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      S_INIT, S_INIT_WAIT, S_IDLE, S_POLL, S_POLL_WAIT, S_GAP, S_WRITE, S_WRITE_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [7:0]       byte_q, byte_d;

   logic        adr_d, we_d, stb_d, busy_d, init_done_d, rdy0_d, rdy1_d;
   logic [3:0]  sel_d;
   logic [31:0] dat_d;

   logic ack_v, tx_busy, any_valid, grant1;
   logic unused_dat;

   // An ack only counts while a request is outstanding.
   assign ack_v      = m_wb_ack_i & m_wb_stb_o;
   assign tx_busy    = m_wb_dat_i[9];
   assign any_valid  = req0_valid_i | req1_valid_i;
   assign unused_dat = ^{m_wb_dat_i[31:10], m_wb_dat_i[8:0]};

`ifdef UART_ARB_RR_EN
   // rr_q names the requester preferred on the next simultaneous request.
   logic rr_q;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         rr_q <= 1'b0;
      end else if (state_q == S_IDLE && any_valid) begin
         rr_q <= ~grant1;
      end
   end

   assign grant1 = req1_valid_i & (~req0_valid_i | rr_q);
`else
   assign grant1 = req1_valid_i & ~req0_valid_i;
`endif

   // State, datapath and registered outputs.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_q      <= S_INIT;
         gap_q        <= '0;
         byte_q       <= '0;
         m_wb_adr_o   <= 1'b0;
         m_wb_we_o    <= 1'b0;
         m_wb_sel_o   <= '0;
         m_wb_dat_o   <= '0;
         m_wb_stb_o   <= 1'b0;
         busy_o       <= 1'b0;
         init_done_o  <= 1'b0;
         req0_ready_o <= 1'b0;
         req1_ready_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         byte_q       <= byte_d;
         m_wb_adr_o   <= adr_d;
         m_wb_we_o    <= we_d;
         m_wb_sel_o   <= sel_d;
         m_wb_dat_o   <= dat_d;
         m_wb_stb_o   <= stb_d;
         busy_o       <= busy_d;
         init_done_o  <= init_done_d;
         req0_ready_o <= rdy0_d;
         req1_ready_o <= rdy1_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:       state_d = S_INIT_WAIT;
         S_INIT_WAIT:  if (ack_v) state_d = S_IDLE;
         S_IDLE:       if (any_valid) state_d = S_POLL;
         S_POLL:       state_d = S_POLL_WAIT;
         S_POLL_WAIT:  if (ack_v) state_d = tx_busy ? S_GAP : S_WRITE;
         S_GAP:        if (gap_q == GAP_LAST) state_d = S_POLL;
         S_WRITE:      state_d = S_WRITE_WAIT;
         S_WRITE_WAIT: if (ack_v) state_d = S_IDLE;
         default:      state_d = S_INIT;
      endcase
   end

   // Output and datapath next values; bus fields hold unless a request is launched.
   always_comb begin
      adr_d       = m_wb_adr_o;
      we_d        = m_wb_we_o;
      sel_d       = m_wb_sel_o;
      dat_d       = m_wb_dat_o;
      stb_d       = m_wb_stb_o;
      busy_d      = busy_o;
      init_done_d = init_done_o;
      rdy0_d      = 1'b0;
      rdy1_d      = 1'b0;
      byte_d      = byte_q;
      gap_d       = gap_q;
      case (state_q)
         S_INIT: begin
            adr_d = 1'b1;
            we_d  = 1'b1;
            sel_d = 4'hF;
            dat_d = CLK_DIV;
            stb_d = 1'b1;
         end
         S_INIT_WAIT: begin
            if (ack_v) begin
               stb_d       = 1'b0;
               init_done_d = 1'b1;
            end
         end
         S_IDLE: begin
            if (any_valid) begin
               byte_d = grant1 ? req1_data_i : req0_data_i;
               rdy0_d = ~grant1;
               rdy1_d = grant1;
               busy_d = 1'b1;
            end
         end
         S_POLL: begin
            // Status lane only, so the rx buffer is not popped.
            adr_d = 1'b0;
            we_d  = 1'b0;
            sel_d = 4'b0010;
            dat_d = '0;
            stb_d = 1'b1;
         end
         S_POLL_WAIT: begin
            if (ack_v) begin
               stb_d = 1'b0;
               gap_d = '0;
            end
         end
         S_GAP: begin
            gap_d = gap_q + GAP_W'(1);
         end
         S_WRITE: begin
            adr_d = 1'b0;
            we_d  = 1'b1;
            sel_d = 4'b0001;
            dat_d = {24'd0, byte_q};
            stb_d = 1'b1;
         end
         S_WRITE_WAIT: begin
            if (ack_v) begin
               stb_d  = 1'b0;
               busy_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter_wb.sv
// Self-checking bench for uart_tx_arbiter_wb: table-driven byte transactions,
// a write scoreboard, a streaming arbitration run and a mid-poll reset.
module tb_uart_tx_arbiter_wb;

   localparam logic [31:0] DIV = 32'd102;
   localparam int GAP = 4;
`ifdef UART_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        v0, v1, rdy0, rdy1;
   logic [7:0]  d0, d1;
   logic        adr, we, stb, ack, busy, init_done;
   logic [3:0]  sel;
   logic [31:0] dat_o, dat_i;
   logic        ack_hold;
   logic        tx_busy;

   int rd_total   = 0;
   int busy_until = 0;

   uart_tx_arbiter_wb #(.CLK_DIV(DIV), .POLL_GAP(GAP)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst_n),
      .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(rdy0),
      .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(rdy1),
      .m_wb_adr_o(adr), .m_wb_dat_o(dat_o), .m_wb_dat_i(dat_i),
      .m_wb_we_o(we), .m_wb_sel_o(sel), .m_wb_stb_o(stb), .m_wb_ack_i(ack),
      .busy_o(busy), .init_done_o(init_done)
   );

   always #5 clk = ~clk;

   // UART slave model: zero-wait ack unless held, status tx_busy from a read budget.
   assign ack     = stb & ~ack_hold;
   assign tx_busy = (rd_total < busy_until);
   assign dat_i   = {16'd0, 6'd0, tx_busy, 1'b0, 8'h5A};

   always @(posedge clk)
      if (stb && ack && !we && !adr) rd_total <= rd_total + 1;

   // Bus monitor.
   logic [31:0] obs_q[$];
   int r0_cnt = 0, r1_cnt = 0, rd_cnt = 0, prot_err = 0, gap_viol = 0, low_run = 0;
   bit prev_pend = 0, prev_stb = 0, prev_r0 = 0, prev_r1 = 0, after_busy = 0;
   logic [37:0] prev_bus = '0;

   always @(negedge clk) begin
      if (rdy0) r0_cnt <= r0_cnt + 1;
      if (rdy1) r1_cnt <= r1_cnt + 1;
      if ((rdy0 && prev_r0) || (rdy1 && prev_r1) || (rdy0 && rdy1)) prot_err <= prot_err + 1;
      if (prev_pend && stb && prev_bus != {adr, we, sel, dat_o}) prot_err <= prot_err + 1;
      if (stb && !prev_stb && !we && !adr && after_busy && low_run < GAP) gap_viol <= gap_viol + 1;
      low_run <= stb ? 0 : low_run + 1;
      if (stb && ack) begin
         if (!we && !adr) begin
            rd_cnt <= rd_cnt + 1;
            if (sel != 4'b0010) prot_err <= prot_err + 1;
         end
         if (we && !adr) begin
            obs_q.push_back(dat_o);
            if (sel != 4'b0001) prot_err <= prot_err + 1;
         end
         after_busy <= (!we && !adr && tx_busy);
      end
      if (!rst_n) after_busy <= 1'b0;
      prev_pend <= stb && !ack;
      prev_stb  <= stb;
      prev_bus  <= {adr, we, sel, dat_o};
      prev_r0   <= rdy0;
      prev_r1   <= rdy1;
   end

   int tests = 0, fails = 0;
   logic [7:0] exp_q[$];
   int obs_rd = 0;
   bit rr_m = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_stb(input string name);
      int n = 0;
      while (!stb && n < 50) begin @(negedge clk); n++; end
      if (!stb) chk({name, "_timeout"}, 32'(stb), 32'd1);
   endtask

   // Compare every queued expectation against the writes the monitor captured.
   task automatic sb_drain(input string name);
      while (exp_q.size() > 0) begin
         logic [7:0] e = exp_q.pop_front();
         if (obs_rd >= obs_q.size()) begin
            chk({name, "_missing_write"}, 32'(obs_q.size()), 32'(obs_rd + 1));
         end else begin
            chk({name, "_write"}, obs_q[obs_rd], {24'd0, e});
            obs_rd++;
         end
      end
      chk({name, "_extra_writes"}, 32'(obs_q.size()), 32'(obs_rd));
   endtask

   function automatic bit pick(input bit a0, input bit a1);
      bit w = (a0 && a1) ? (RR_EN ? rr_m : 1'b0) : (a1 && !a0);
      if (RR_EN) rr_m = ~w;
      return w;
   endfunction

   task automatic run_one(input string name, input bit a0, input logic [7:0] b0,
                          input bit a1, input logic [7:0] b1, input int k,
                          input int exp_reads, input int exp_cycles);
      int r0s = r0_cnt, r1s = r1_cnt, rds = rd_cnt, pe = prot_err, gv = gap_viol;
      int n = 0;
      bit w;
      busy_until = rd_total + k;
      w = pick(a0, a1);
      exp_q.push_back(w ? b1 : b0);
      v0 = a0; d0 = b0; v1 = a1; d1 = b1;
      while (!(rdy0 || rdy1) && n < 100) begin @(negedge clk); n++; end
      v0 = 1'b0; v1 = 1'b0;
      if (!(rdy0 || rdy1)) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
      n = 1;
      while (busy && n < 300) begin @(negedge clk); if (busy) n++; end
      chk({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
      chk({name, "_rdy0"}, 32'(r0_cnt - r0s), 32'(!w));
      chk({name, "_rdy1"}, 32'(r1_cnt - r1s), 32'(w));
      chk({name, "_reads"}, 32'(rd_cnt - rds), 32'(exp_reads));
      chk({name, "_gap"}, 32'(gap_viol - gv), 32'd0);
      chk({name, "_protocol"}, 32'(prot_err - pe), 32'd0);
      sb_drain(name);
   endtask

   typedef struct {
      bit         a0;
      logic [7:0] b0;
      bit         a1;
      logic [7:0] b1;
      int         k;
      int         exp_reads;
      int         exp_cycles;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int got;
      int r1s;
      int exp_r1;
      vecs[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 0, 1, 4};
      vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h55, 0, 1, 4};
      vecs[2] = '{1'b1, 8'h10, 1'b0, 8'h00, 3, 4, 4 + 3 * (2 + GAP)};
      vecs[3] = '{1'b1, 8'h22, 1'b1, 8'h33, 0, 1, 4};
      vecs[4] = '{1'b1, 8'h44, 1'b1, 8'h66, 1, 2, 4 + (2 + GAP)};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hFF, 2, 3, 4 + 2 * (2 + GAP)};

      rst_n = 1'b0; ack_hold = 1'b0;
      v0 = 1'b1; d0 = 8'h41; v1 = 1'b0; d1 = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_stb", 32'(stb), 32'd0);
      chk("reset_bus", {26'd0, adr, we, sel}, 32'd0);
      chk("reset_dat", dat_o, 32'd0);
      chk("reset_flags", {28'd0, busy, init_done, rdy0, rdy1}, 32'd0);
      rst_n = 1'b1;

      // Divider programming; req0 is held valid but must not be served yet.
      wait_stb("init");
      chk("init_adr_we_sel", {26'd0, adr, we, sel}, {26'd0, 1'b1, 1'b1, 4'hF});
      chk("init_dat", dat_o, DIV);
      chk("init_done_early", 32'(init_done), 32'd0);
      @(negedge clk);
      chk("init_done", 32'(init_done), 32'd1);
      chk("init_stb_drop", 32'(stb), 32'd0);
      chk("no_ready_before_init", 32'(r0_cnt), 32'd0);
      v0 = 1'b0;
      repeat (4) @(negedge clk);
      chk("dropped_valid_not_served", 32'(r0_cnt + r1_cnt), 32'd0);
      chk("dropped_valid_busy", 32'(busy), 32'd0);

      foreach (vecs[i])
         run_one($sformatf("vec%0d", i), vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                 vecs[i].k, vecs[i].exp_reads, vecs[i].exp_cycles);

      // Streaming: both requesters valid for four grants.
      r1s = r1_cnt; exp_r1 = 0; got = 0;
      busy_until = rd_total;
      for (int i = 0; i < 4; i++) begin
         bit w = pick(1'b1, 1'b1);
         exp_q.push_back(w ? 8'hB0 : 8'hA0);
         exp_r1 += int'(w);
      end
      v0 = 1'b1; d0 = 8'hA0; v1 = 1'b1; d1 = 8'hB0;
      for (int n = 0; n < 400 && got < 4; n++) begin
         @(negedge clk);
         if (rdy0 || rdy1) got++;
         if (got == 4) begin v0 = 1'b0; v1 = 1'b0; end
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("stream_grants", 32'(got), 32'd4);
      for (int n = 0; n < 50 && busy; n++) @(negedge clk);
      chk("stream_r1", 32'(r1_cnt - r1s), 32'(exp_r1));
      sb_drain("stream");

      // Reset while stalled in the status poll.
      ack_hold = 1'b1;
      v0 = 1'b1; d0 = 8'h99;
      wait_stb("poll_stall");
      v0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("stall_holds_stb", {30'd0, stb, we}, {30'd0, 1'b1, 1'b0});
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_reset_stb", 32'(stb), 32'd0);
      chk("mid_reset_flags", {30'd0, busy, init_done}, 32'd0);
      ack_hold = 1'b0;
      rst_n = 1'b1;
      wait_stb("reinit");
      chk("reinit_adr_we", {30'd0, adr, we}, 32'd3);
      chk("reinit_dat", dat_o, DIV);
      for (int n = 0; n < 20 && !init_done; n++) @(negedge clk);
      chk("reinit_done", 32'(init_done), 32'd1);
      repeat (10) @(negedge clk);
      chk("dropped_byte_never_written", 32'(obs_q.size()), 32'(obs_rd));

      // Arbitration state restarts: req0 wins the first tie.
      rr_m = 1'b0;
      run_one("post_reset_tie", 1'b1, 8'hA0, 1'b1, 8'hB0, 0, 1, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
